// File: rtl/alu_arbiter_pkg.sv
// Shared CPU types for the ALU arbiter: word/opcode widths and arbiter state encoding.
package alu_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'b0000,
    ALU_SRL  = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_NOR  = 4'b0111,
    ALU_SLT  = 4'b1010,
    ALU_SLTU = 4'b1011
  } aluop_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_EXEC,
    ARB_RESP
  } alu_arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester channels, the shared result/flags and the link to the ALU.
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic   req0;
  logic   req1;
  aluop_t aluop0;
  aluop_t aluop1;
  word_t  porta0;
  word_t  portb0;
  word_t  porta1;
  word_t  portb1;
  logic   done0;
  logic   done1;
  word_t  result;
  logic   negative;
  logic   zero;
  logic   overflow;
  aluop_t alu_op;
  word_t  alu_a;
  word_t  alu_b;
  word_t  alu_out;
  logic   alu_neg;
  logic   alu_zero;
  logic   alu_ovf;

  // Arbiter side
  modport slave (
    input  req0, req1, aluop0, aluop1, porta0, portb0, porta1, portb1,
    input  alu_out, alu_neg, alu_zero, alu_ovf,
    output done0, done1, result, negative, zero, overflow,
    output alu_op, alu_a, alu_b
  );

  // Requester side
  modport master (
    output req0, req1, aluop0, aluop1, porta0, portb0, porta1, portb1,
    input  done0, done1, result, negative, zero, overflow
  );

  modport alu (
    input  alu_op, alu_a, alu_b,
    output alu_out, alu_neg, alu_zero, alu_ovf
  );

endinterface

// File: rtl/alu_arbiter_rr_picker.sv
// Two-way round-robin picker; the current owner can be masked out so RESP only hands over.
module alu_rr_picker (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  input  logic exclude_valid,
  input  logic exclude_id,
  output logic grant_valid,
  output logic grant_id
);

  logic eff0;
  logic eff1;

  assign eff0 = req0 && !(exclude_valid && (exclude_id == 1'b0));
  assign eff1 = req1 && !(exclude_valid && (exclude_id == 1'b1));

  always_comb begin
    grant_valid = eff0 || eff1;
    grant_id    = 1'b0;
    if (eff0 && eff1) begin
      grant_id = ~last_grant;
    end else if (eff1) begin
      grant_id = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Time-shares one ALU between two requesters: latch winner's operands, execute one
// cycle, register result/flags, then pulse done to the owner.
module alu_arbiter (
  input logic          CLK,
  input logic          nRST,
  alu_arbiter_if.slave bus
);
  import alu_arbiter_pkg::*;

  alu_arb_state_t state;
  logic           last_grant;
  logic           owner;
  aluop_t         op_q;
  word_t          a_q;
  word_t          b_q;

  logic           grant_valid;
  logic           grant_id;
  logic           in_resp;
  aluop_t         grant_op;
  word_t          grant_a;
  word_t          grant_b;

  assign in_resp = (state == ARB_RESP);

  alu_rr_picker u_picker (
    .req0          (bus.req0),
    .req1          (bus.req1),
    .last_grant    (last_grant),
    .exclude_valid (in_resp),
    .exclude_id    (owner),
    .grant_valid   (grant_valid),
    .grant_id      (grant_id)
  );

  assign grant_op = grant_id ? bus.aluop1 : bus.aluop0;
  assign grant_a  = grant_id ? bus.porta1 : bus.porta0;
  assign grant_b  = grant_id ? bus.portb1 : bus.portb0;

  // IDLE and RESP share the grant path, so a waiting requester follows RESP with no bubble.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= ARB_IDLE;
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      op_q         <= aluop_t'(4'b0000);
      a_q          <= '0;
      b_q          <= '0;
      bus.result   <= '0;
      bus.negative <= 1'b0;
      bus.zero     <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE, ARB_RESP: begin
          if (grant_valid) begin
            op_q       <= grant_op;
            a_q        <= grant_a;
            b_q        <= grant_b;
            owner      <= grant_id;
            last_grant <= grant_id;
            state      <= ARB_EXEC;
          end else begin
            state <= ARB_IDLE;
          end
        end
        ARB_EXEC: begin
          bus.result   <= bus.alu_out;
          bus.negative <= bus.alu_neg;
          bus.zero     <= bus.alu_zero;
          bus.overflow <= bus.alu_ovf;
          state        <= ARB_RESP;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.done0  = in_resp && !owner;
  assign bus.done1  = in_resp && owner;
  assign bus.alu_op = op_q;
  assign bus.alu_a  = a_q;
  assign bus.alu_b  = b_q;

endmodule
